// File: rtl/port_pkg.sv
// rtl/port_pkg.sv - shared port count, pointer width and FIFO status types
package port_pkg;

  // Number of ports for a given select width.
  function automatic int port_count(input int port_exp);
    return 1 << port_exp;
  endfunction

  // Pointer width: one extra wrap bit distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_status_t;

endpackage

// File: rtl/port_fifo.sv
// rtl/port_fifo.sv - show-ahead FIFO with wrap-bit pointers and unreset storage
module port_fifo
  import port_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output fifo_status_t      status
);

  localparam int PW = ptr_w(FIFO_DEPTH);
  localparam int AW = PW - 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Status from the pre-edge pointers; requests are gated so a push to a
  // full FIFO or a pop from an empty one never takes effect.
  always_comb begin
    status.empty = (wr_ptr == rd_ptr);
    status.full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    do_push      = push && !status.full;
    do_pop       = pop && !status.empty;
  end

  assign head = mem[rd_ptr[AW-1:0]];

  // Pointer update; power-of-two depth lets the pointers wrap on their own.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/port_hub.sv
// rtl/port_hub.sv - CPU/external port hub with per-port RX/TX FIFOs; PORT_HUB_IRQ_EN adds irq and irq_mask
module port_hub
  import port_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int PORT_EXP   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              cpu_read,
  input  logic                                              cpu_write,
  input  logic [PORT_EXP-1:0]                               cpu_addr,
  input  logic [DATA_W-1:0]                                 cpu_d_in,
  output logic [DATA_W-1:0]                                 cpu_d_out,
  output logic                                              cpu_stall,
  input  logic [port_count(PORT_EXP)-1:0][DATA_W-1:0]       ext_d_in,
  input  logic [port_count(PORT_EXP)-1:0]                   ext_valid_in,
  output logic [port_count(PORT_EXP)-1:0]                   ext_ready_in,
  output logic [port_count(PORT_EXP)-1:0][DATA_W-1:0]       ext_d_out,
  output logic [port_count(PORT_EXP)-1:0]                   ext_valid_out,
  input  logic [port_count(PORT_EXP)-1:0]                   ext_ready_out,
  output logic [port_count(PORT_EXP)-1:0]                   port_inform_write,
  output logic [port_count(PORT_EXP)-1:0]                   port_inform_read
`ifdef PORT_HUB_IRQ_EN
  ,
  output logic                                              irq
`endif
);

  localparam int PORT_COUNT = port_count(PORT_EXP);

  fifo_status_t            rx_st   [PORT_COUNT];
  fifo_status_t            tx_st   [PORT_COUNT];
  logic [DATA_W-1:0]       rx_head [PORT_COUNT];
  logic [PORT_COUNT-1:0]   rx_pop;
  logic [PORT_COUNT-1:0]   tx_push;
  logic                    mask_wr;
  logic                    wr_ok;
  logic                    rd_ok;

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
    port_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_rx (
      .clk       (clk),
      .reset     (reset),
      .push      (ext_valid_in[p]),
      .push_data (ext_d_in[p]),
      .pop       (rx_pop[p]),
      .head      (rx_head[p]),
      .status    (rx_st[p])
    );

    port_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
      .clk       (clk),
      .reset     (reset),
      .push      (tx_push[p]),
      .push_data (cpu_d_in),
      .pop       (ext_ready_out[p]),
      .head      (ext_d_out[p]),
      .status    (tx_st[p])
    );

    assign ext_ready_in[p]  = !rx_st[p].full;
    assign ext_valid_out[p] = !tx_st[p].empty;
  end

  // CPU request decode: read and write are judged independently against
  // their own FIFO, and a stalled side produces no push or pop.
  always_comb begin
    mask_wr = 1'b0;
`ifdef PORT_HUB_IRQ_EN
    mask_wr = cpu_write && (cpu_addr == '1) && cpu_d_in[DATA_W-1];
`endif
    wr_ok     = cpu_write && !mask_wr && !tx_st[cpu_addr].full;
    rd_ok     = cpu_read && !rx_st[cpu_addr].empty;
    cpu_stall = (cpu_write && !mask_wr && tx_st[cpu_addr].full) ||
                (cpu_read && rx_st[cpu_addr].empty);
    tx_push           = '0;
    rx_pop            = '0;
    tx_push[cpu_addr] = wr_ok;
    rx_pop[cpu_addr]  = rd_ok;
  end

  // Read data capture and one-cycle accept strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cpu_d_out         <= '0;
      port_inform_write <= '0;
      port_inform_read  <= '0;
    end else begin
      port_inform_write <= tx_push;
      port_inform_read  <= rx_pop;
      if (rd_ok) cpu_d_out <= rx_head[cpu_addr];
    end
  end

`ifdef PORT_HUB_IRQ_EN
  logic [PORT_COUNT-1:0] irq_mask;
  logic [PORT_COUNT-1:0] rx_nonempty;

  // Collect per-port RX occupancy for the interrupt.
  always_comb begin
    rx_nonempty = '0;
    for (int p = 0; p < PORT_COUNT; p++) rx_nonempty[p] = !rx_st[p].empty;
  end

  // Mask register and registered interrupt output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_mask <= '0;
      irq      <= 1'b0;
    end else begin
      if (mask_wr) irq_mask <= cpu_d_in[PORT_COUNT-1:0];
      irq <= |(rx_nonempty & irq_mask);
    end
  end
`endif

endmodule
